// File: rtl/issue_div_pkg.sv
// Shared definitions for the issue-stage units: default widths and the
// divide unit's FSM state encoding.
package issue_div_pkg;

  localparam int DIV_DATA_W = 32;
  localparam int DIV_TAG_W  = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    WAIT = 2'd2
  } divState_t;

  function automatic int cntWidth(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/issue_div_if.sv
// Handshake between the divide equeue, the divide unit and the CDB arbiter.
interface issue_div_if
  import issue_div_pkg::*;
#(
  parameter int DATA_W = DIV_DATA_W,
  parameter int TAG_W  = DIV_TAG_W
) ();

  logic              issuediv_ready;
  logic [DATA_W-1:0] issuediv_rsdata;
  logic [DATA_W-1:0] issuediv_rtdata;
  logic [TAG_W-1:0]  issuediv_rdtag;
  logic              issuediv_done;
  logic              div_cdb_req;
  logic              div_cdb_grant;
  logic [DATA_W-1:0] div_cdb_data;
  logic [DATA_W-1:0] div_cdb_rem;
  logic [TAG_W-1:0]  div_cdb_tag;
  logic              div_busy;

  modport slave (
    input  issuediv_ready, issuediv_rsdata, issuediv_rtdata, issuediv_rdtag,
    input  div_cdb_grant,
    output issuediv_done, div_cdb_req, div_cdb_data, div_cdb_rem, div_cdb_tag,
    output div_busy
  );

  modport master (
    output issuediv_ready, issuediv_rsdata, issuediv_rtdata, issuediv_rdtag,
    output div_cdb_grant,
    input  issuediv_done, div_cdb_req, div_cdb_data, div_cdb_rem, div_cdb_tag,
    input  div_busy
  );

endinterface

// File: rtl/issue_div.sv
// Iterative signed divider (MIPS DIV semantics): one restoring quotient bit
// per cycle on magnitudes, sign fix-up at the end, result held for the CDB.
module issue_div
  import issue_div_pkg::*;
#(
  parameter int DATA_W = DIV_DATA_W,
  parameter int TAG_W  = DIV_TAG_W
) (
  input  logic        clk,
  input  logic        reset,
  issue_div_if.slave  bus
);

  localparam int                CNT_W    = cntWidth(DATA_W);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(DATA_W - 1);
  localparam logic [DATA_W-1:0] ONE      = DATA_W'(1);

  divState_t r_state;
  divState_t w_nextState;
  logic      w_accept;
  logic      w_lastStep;

  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_quot;
  logic [DATA_W-1:0] r_rem;
  logic [DATA_W-1:0] r_divisor;
  logic              r_divZero;
  logic              r_negQ;
  logic              r_negR;
  logic [TAG_W-1:0]  r_tag;

  logic [DATA_W-1:0] r_data;
  logic [DATA_W-1:0] r_remOut;
  logic [TAG_W-1:0]  r_outTag;

  logic [DATA_W-1:0] w_rsAbs;
  logic [DATA_W-1:0] w_rtAbs;
  logic [DATA_W:0]   w_trial;
  logic [DATA_W:0]   w_diff;
  logic              w_qBit;
  logic [DATA_W-1:0] w_quotNext;
  logic [DATA_W-1:0] w_remNext;
  logic [DATA_W-1:0] w_quotSigned;
  logic [DATA_W-1:0] w_remSigned;

  assign w_rsAbs = bus.issuediv_rsdata[DATA_W-1] ? (~bus.issuediv_rsdata + ONE)
                                                 : bus.issuediv_rsdata;
  assign w_rtAbs = bus.issuediv_rtdata[DATA_W-1] ? (~bus.issuediv_rtdata + ONE)
                                                 : bus.issuediv_rtdata;

  // r_quot starts as the dividend and shifts quotient bits in from the right.
  assign w_trial    = {r_rem, r_quot[DATA_W-1]};
  assign w_diff     = w_trial - {1'b0, r_divisor};
  assign w_qBit     = w_trial[DATA_W] | ~w_diff[DATA_W];
  assign w_remNext  = w_qBit ? w_diff[DATA_W-1:0] : w_trial[DATA_W-1:0];
  assign w_quotNext = {r_quot[DATA_W-2:0], w_qBit};

  assign w_quotSigned = r_divZero ? '1 : (r_negQ ? (~w_quotNext + ONE) : w_quotNext);
  assign w_remSigned  = r_negR ? (~w_remNext + ONE) : w_remNext;

  assign w_lastStep = (r_state == CALC) && (r_cnt == LAST_CNT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_accept    = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.issuediv_ready) begin
          w_accept    = 1'b1;
          w_nextState = CALC;
        end
      end
      CALC: begin
        if (r_cnt == LAST_CNT) begin
          w_nextState = WAIT;
        end
      end
      WAIT: begin
        if (bus.div_cdb_grant) begin
          w_nextState = IDLE;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt     <= '0;
      r_quot    <= '0;
      r_rem     <= '0;
      r_divisor <= '0;
      r_divZero <= 1'b0;
      r_negQ    <= 1'b0;
      r_negR    <= 1'b0;
      r_tag     <= '0;
    end else if (w_accept) begin
      r_cnt     <= '0;
      r_quot    <= w_rsAbs;
      r_rem     <= '0;
      r_divisor <= w_rtAbs;
      r_divZero <= (bus.issuediv_rtdata == '0);
      r_negQ    <= bus.issuediv_rsdata[DATA_W-1] ^ bus.issuediv_rtdata[DATA_W-1];
      r_negR    <= bus.issuediv_rsdata[DATA_W-1];
      r_tag     <= bus.issuediv_rdtag;
    end else if (r_state == CALC) begin
      r_cnt  <= r_cnt + CNT_W'(1);
      r_quot <= w_quotNext;
      r_rem  <= w_remNext;
    end
  end

  // Result registers only load on the final step, so they stay frozen in WAIT.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_data   <= '0;
      r_remOut <= '0;
      r_outTag <= '0;
    end else if (w_lastStep) begin
      r_data   <= w_quotSigned;
      r_remOut <= w_remSigned;
      r_outTag <= r_tag;
    end
  end

  assign bus.issuediv_done = w_accept;
  assign bus.div_cdb_req   = (r_state == WAIT);
  assign bus.div_cdb_data  = r_data;
  assign bus.div_cdb_rem   = r_remOut;
  assign bus.div_cdb_tag   = r_outTag;
  assign bus.div_busy      = (r_state != IDLE);

endmodule

// File: tb/tb_issue_div.sv
// Scoreboard bench for issue_div: stimulus pushes reference results at accept,
// a negedge monitor pops and compares whenever the unit requests the CDB.
module tb_issue_div;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic [5:0]  tag;
    int          acc;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   grantDelay = 0;
  int   lastGrantCycle = -1;
  int   lastAccept = -1;
  int   reqAge = 0;
  bit   reqPrev = 1'b0;
  bit   haveCur = 1'b0;
  exp_t cur;
  exp_t sb[$];

  issue_div_if #(.DATA_W(32), .TAG_W(6)) bus ();

  issue_div #(.DATA_W(32), .TAG_W(6)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Reference: signed division truncating toward zero, with the two MIPS corner cases.
  function automatic void refDiv(input logic [31:0] rs, input logic [31:0] rt,
                                 output logic [31:0] q, output logic [31:0] r);
    if (rt == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = rs;
    end else if (rs == 32'h8000_0000 && rt == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'd0;
    end else begin
      q = 32'($signed(rs) / $signed(rt));
      r = 32'($signed(rs) % $signed(rt));
    end
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)",
               name, actual, expected, cyc);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] rs, input logic [31:0] rt,
                               input logic [5:0] tag);
    exp_t e;
    int   waited;
    bit   got;
    waited = 0;
    got = 1'b0;
    bus.issuediv_ready  = 1'b1;
    bus.issuediv_rsdata = rs;
    bus.issuediv_rtdata = rt;
    bus.issuediv_rdtag  = tag;
    while (!got && waited < 200) begin
      @(negedge clk);
      if (bus.issuediv_done === 1'b1) got = 1'b1;
      else waited++;
    end
    if (got) begin
      refDiv(rs, rt, e.q, e.r);
      e.tag = tag;
      e.acc = cyc;
      sb.push_back(e);
      lastAccept = cyc;
    end else begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout: no done after %0d cycles, expected done=1", waited);
    end
    @(posedge clk);
    #1;
    bus.issuediv_ready = 1'b0;
  endtask

  // CDB arbiter model: grants after grantDelay cycles of request, plus spurious grants otherwise.
  initial begin
    bus.div_cdb_grant = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!reset) begin
        bus.div_cdb_grant = 1'b0;
        reqAge = 0;
      end else if (bus.div_cdb_req === 1'b1) begin
        if (reqAge >= grantDelay) begin
          bus.div_cdb_grant = 1'b1;
          lastGrantCycle = cyc;
          reqAge = 0;
        end else begin
          bus.div_cdb_grant = 1'b0;
          reqAge++;
        end
      end else begin
        bus.div_cdb_grant = ($urandom_range(0, 5) == 0);
        reqAge = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      reqPrev = 1'b0;
      haveCur = 1'b0;
    end else begin
      if (bus.issuediv_done === 1'b1) begin
        checkOutput("busy_at_accept", {31'd0, bus.div_busy}, 32'd0);
      end
      if (bus.div_cdb_req === 1'b1) begin
        checkOutput("done_in_wait", {31'd0, bus.issuediv_done}, 32'd0);
        checkOutput("busy_in_wait", {31'd0, bus.div_busy}, 32'd1);
        if (!reqPrev) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_req: req=1 with no operation outstanding (cycle %0d)", cyc);
          end else begin
            cur = sb.pop_front();
            haveCur = 1'b1;
            checkOutput("req_latency", 32'(cyc - cur.acc), 32'd33);
          end
        end
        if (haveCur) begin
          checkOutput("cdb_data", bus.div_cdb_data, cur.q);
          checkOutput("cdb_rem", bus.div_cdb_rem, cur.r);
          checkOutput("cdb_tag", {26'd0, bus.div_cdb_tag}, {26'd0, cur.tag});
          if (bus.div_cdb_grant === 1'b1) haveCur = 1'b0;
        end
      end
      reqPrev = (bus.div_cdb_req === 1'b1);
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    int          mode;
    int          waited;

    bus.issuediv_ready  = 1'b0;
    bus.issuediv_rsdata = '0;
    bus.issuediv_rtdata = '0;
    bus.issuediv_rdtag  = '0;
    #2 reset = 1'b0;
    #2;
    checkOutput("reset_done", {31'd0, bus.issuediv_done}, 32'd0);
    checkOutput("reset_req", {31'd0, bus.div_cdb_req}, 32'd0);
    checkOutput("reset_data", bus.div_cdb_data, 32'd0);
    checkOutput("reset_rem", bus.div_cdb_rem, 32'd0);
    checkOutput("reset_tag", {26'd0, bus.div_cdb_tag}, 32'd0);
    checkOutput("reset_busy", {31'd0, bus.div_busy}, 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    grantDelay = 0;
    applyStimulus(32'h0000_000E, 32'h0000_0007, 6'h09);
    applyStimulus(32'hFFFF_FFF9, 32'h0000_0002, 6'h15);
    applyStimulus(32'h0000_1234, 32'h0000_0000, 6'h2A);

    grantDelay = 5;
    applyStimulus(32'd1000, 32'd3, 6'h11);
    applyStimulus(32'hFFFF_FC18, 32'hFFFF_FFFD, 6'h12);
    checkOutput("accept_after_grant", 32'(lastAccept), 32'(lastGrantCycle + 1));
    grantDelay = 0;

    applyStimulus(32'h0000_5555, 32'h0000_0003, 6'h3F);
    repeat (9) @(posedge clk);
    #3 reset = 1'b0;
    #1;
    checkOutput("midcalc_done", {31'd0, bus.issuediv_done}, 32'd0);
    checkOutput("midcalc_req", {31'd0, bus.div_cdb_req}, 32'd0);
    checkOutput("midcalc_data", bus.div_cdb_data, 32'd0);
    checkOutput("midcalc_rem", bus.div_cdb_rem, 32'd0);
    checkOutput("midcalc_tag", {26'd0, bus.div_cdb_tag}, 32'd0);
    checkOutput("midcalc_busy", {31'd0, bus.div_busy}, 32'd0);
    sb.delete();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    repeat (45) @(posedge clk);
    #1;
    checkOutput("discarded_req", {31'd0, bus.div_cdb_req}, 32'd0);
    checkOutput("discarded_busy", {31'd0, bus.div_busy}, 32'd0);

    applyStimulus(32'h8000_0000, 32'hFFFF_FFFF, 6'h07);

    for (int i = 0; i < 24; i++) begin
      mode = $urandom_range(0, 5);
      ra = $urandom;
      if ($urandom_range(0, 3) == 0) ra = 32'($urandom_range(0, 200));
      case (mode)
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 15));
        2: rb = ~32'($urandom_range(1, 15)) + 32'd1;
        3: rb = 32'hFFFF_FFFF;
        4: rb = $urandom;
        default: rb = $urandom >> 16;
      endcase
      grantDelay = $urandom_range(0, 3);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      applyStimulus(ra, rb, 6'($urandom));
    end

    waited = 0;
    while ((sb.size() != 0 || haveCur) && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    if (sb.size() != 0 || haveCur) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain_timeout: %0d results still pending, expected 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/issue_div.md
ISSUE_DIV -- requirements
Module: issue_div

Interface
REQ-001 Parameter DATA_W, default 32, operand/result width.
REQ-002 Parameter TAG_W, default 6, ROB/rename tag width.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 issuediv_ready  in  1  divide equeue holds a ready entry with both operands valid.
REQ-006 issuediv_rsdata  in  DATA_W  dividend.
REQ-007 issuediv_rtdata  in  DATA_W  divisor.
REQ-008 issuediv_rdtag  in  TAG_W  destination tag.
REQ-009 issuediv_done  out  1  entry accepted; equeue dequeues its head this cycle.
REQ-010 div_cdb_req  out  1  result waiting for CDB.
REQ-011 div_cdb_grant  in  1  CDB arbiter grants the bus this cycle.
REQ-012 div_cdb_data  out  DATA_W  quotient (LO).
REQ-013 div_cdb_rem  out  DATA_W  remainder (HI).
REQ-014 div_cdb_tag  out  TAG_W  destination tag of the result.
REQ-015 div_busy  out  1  unit not in IDLE.

Function
REQ-016 FSM SHALL have exactly three states: IDLE, CALC, WAIT.
REQ-017 IDLE: issuediv_done SHALL be combinationally high iff issuediv_ready=1; on that edge SHALL capture |rs|, |rt|, signs, tag; clear counter; go CALC.
REQ-018 issuediv_done SHALL never be high outside IDLE; no more than one operand set in flight.
REQ-019 CALC: one restoring-division quotient bit per cycle, MSB first, 5-bit counter; after exactly 32 CALC cycles go WAIT.
REQ-020 On CALC->WAIT edge, SHALL register sign-corrected results: quotient negative iff rs[31]^rt[31], remainder takes sign of rs, truncation toward zero (MIPS DIV).
REQ-021 Latency: accept cycle C0, CALC C1..C32, div_cdb_req high from C33.
REQ-022 WAIT: div_cdb_req=1; data/rem/tag SHALL stay stable until grant.
REQ-023 div_cdb_grant while WAIT: go IDLE next edge; new accept earliest the cycle after grant.
REQ-024 div_cdb_grant outside WAIT SHALL be ignored.
REQ-025 Divisor zero: quotient SHALL be all ones, remainder = rs, same 33-cycle latency.
REQ-026 0x80000000 / 0xFFFFFFFF SHALL yield quotient 0x80000000, remainder 0, no trap.
REQ-027 Arithmetic unsigned internally at DATA_W bits (partial remainder DATA_W+1 bits); sign fix by two's-complement negate.
REQ-028 div_busy = (state != IDLE).

Reset
REQ-029 reset low SHALL, asynchronously at any state incl. mid-CALC/WAIT, force IDLE, counter 0, operand/result registers 0.
REQ-030 During/after reset: issuediv_done=0, div_cdb_req=0, div_cdb_data=0, div_cdb_rem=0, div_cdb_tag=0, div_busy=0.
REQ-031 An operation interrupted by reset SHALL be discarded; no CDB request for it.

Structure
REQ-032 DATA_W, TAG_W defaults and FSM state encodings SHALL live in the shared cobalt package/header, reused by the other issue units.
REQ-033 Single flat module; no sub-module—iteration step is inline datapath.

Verification
REQ-034 rs=0xE, rt=0x7, tag=0x9, ready pulsed -> done 1 cycle, req at C33, data=0x2, rem=0x0, tag=0x9.
REQ-035 rs=0xFFFFFFF9 (-7), rt=0x2 -> data=0xFFFFFFFD, rem=0xFFFFFFFF.
REQ-036 rt=0, rs=0x1234 -> data=0xFFFFFFFF, rem=0x1234, req at C33.
REQ-037 ready held high, two entries queued, grant delayed 5 cycles -> req/data stable 5 cycles, second done exactly 1 cycle after grant, second req 33 cycles after that.
REQ-038 reset asserted at C10 of CALC -> outputs zero immediately, no req; post-reset accept of 0x80000000/0xFFFFFFFF -> data=0x80000000, rem=0.
